// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants and helpers
// for the vga_fb scanout engine.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  function automatic bit legal_bpp(input int b);
    return b == 1 || b == 2 || b == 4 || b == 8;
  endfunction

  function automatic bit legal_scale(input int s);
    return s == 1 || s == 2;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/vga_vram.sv
// vga_vram: 8-bit simple dual-port video RAM,
// write port A, registered read port B.
module vga_vram #(
  parameter int DEPTH = 6144,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    q
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/vga_fb.sv
// vga_fb: framebuffer scanout with timing counters,
// prefetching fetch pointers, pixel shifter and page flip.
module vga_fb
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int BPP        = 1,
  parameter int SCALE      = 1,
  parameter int VMEM_BYTES = 6144,
  parameter int AW         = clog2(VMEM_BYTES),
  parameter int STRIDE     = H_ACTIVE * BPP / (8 * SCALE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en,
  input  logic [AW-1:0]  vmem_in_addr,
  input  logic [7:0]     vmem_in_data,
  input  logic           vmem_we,
  input  logic [AW-1:0]  base_in,
  input  logic           base_we,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [BPP-1:0] rgb,
  output logic           frame_irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = clog2(H_TOTAL);
  localparam int VW = clog2(V_TOTAL);
  localparam int PPB = 8 * SCALE / BPP;
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [AW-1:0] line_addr, rd_addr, rd_src;
  logic [AW-1:0] base_active, base_pend;
  logic [7:0]    q, shreg, shn;
  logic          hs1, vs1, act1, ld1, adv1;
  logic          h_last, v_last, act, sub0, rep0;
  logic          grp_last, fetch, flip, hs_win, vs_win;

  function automatic logic [AW-1:0] wrap_add(
    input logic [AW-1:0] a,
    input int unsigned   inc
  );
    logic [AW:0] s;
    s = {1'b0, a} + (AW+1)'(inc);
    if (s >= (AW+1)'(VMEM_BYTES))
      s = s - (AW+1)'(VMEM_BYTES);
    return s[AW-1:0];
  endfunction

  vga_vram #(
    .DEPTH (VMEM_BYTES),
    .AW    (AW)
  ) u_vram (
    .clk   (clk),
    .we    (vmem_we),
    .waddr (vmem_in_addr),
    .wdata (vmem_in_data),
    .re    (fetch),
    .raddr (rd_src),
    .q     (q)
  );

  always_comb begin
    h_last   = hcnt == HW'(H_TOTAL - 1);
    v_last   = vcnt == VW'(V_TOTAL - 1);
    act      = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    sub0     = (hcnt & HW'(PPB - 1)) == '0;
    rep0     = (SCALE == 1) || !hcnt[0];
    grp_last = (SCALE == 1) || vcnt[0];
    rd_src   = rd_addr;
    if (hcnt == '0)
      rd_src = (vcnt == '0) ? base_active : line_addr;
    fetch    = pix_en && act && sub0;
    flip     = pix_en && hcnt == '0 && vcnt == VW'(V_ACTIVE);
    hs_win   = hcnt >= HW'(H_ACTIVE + H_FP) &&
               hcnt <  HW'(H_ACTIVE + H_FP + H_SYNC);
    vs_win   = vcnt >= VW'(V_ACTIVE + V_FP) &&
               vcnt <  VW'(V_ACTIVE + V_FP + V_SYNC);
    shn      = shreg << BPP;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Line pointer follows source lines; SCALE=2 reuses each line twice.
  always_ff @(posedge clk) begin
    if (!rst) begin
      line_addr <= '0;
      rd_addr   <= '0;
    end else if (pix_en) begin
      if (fetch)
        rd_addr <= wrap_add(rd_src, 1);
      else if (hcnt == '0)
        rd_addr <= rd_src;
      if (hcnt == '0 && vcnt == '0)
        line_addr <= base_active;
      else if (h_last && vcnt < VW'(V_ACTIVE) && grp_last)
        line_addr <= wrap_add(line_addr, STRIDE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_pend   <= '0;
      base_active <= '0;
      frame_irq   <= 1'b0;
    end else begin
      frame_irq <= flip;
      if (base_we)
        base_pend <= base_in;
      if (flip)
        base_active <= base_we ? base_in : base_pend;
    end
  end

  // Stage 1 captures counter decode; stage 2 drives the pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hs1   <= !HS_ON;
      vs1   <= !VS_ON;
      act1  <= 1'b0;
      ld1   <= 1'b0;
      adv1  <= 1'b0;
      hsync <= !HS_ON;
      vsync <= !VS_ON;
      de    <= 1'b0;
      rgb   <= '0;
      shreg <= '0;
    end else if (pix_en) begin
      hs1   <= hs_win ? HS_ON : !HS_ON;
      vs1   <= vs_win ? VS_ON : !VS_ON;
      act1  <= act;
      ld1   <= act && sub0;
      adv1  <= act && rep0 && !sub0;
      hsync <= hs1;
      vsync <= vs1;
      de    <= act1;
      if (!act1) begin
        rgb <= '0;
      end else if (ld1) begin
        shreg <= q;
        rgb   <= q[7 -: BPP];
      end else if (adv1) begin
        shreg <= shn;
        rgb   <= shn[7 -: BPP];
      end
    end
  end

endmodule

// File: tb/tb_vga_fb.sv
// tb_vga_fb: directed checks of vga_fb on a reduced
// 16x6 raster, 1bpp/1x and 4bpp/2x instances.
module tb_vga_fb;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pix_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    data = '0;
  logic          we1 = 1'b0;
  logic          we4 = 1'b0;
  logic [AW-1:0] base_in = '0;
  logic          base_we = 1'b0;

  logic       hs1, vs1, de1, irq1;
  logic [0:0] rgb1;
  logic       hs4, vs4, de4, irq4;
  logic [3:0] rgb4;

  int total = 0;
  int bad = 0;
  int irq_n1 = 0;
  int irq_n4 = 0;
  int irq_at1 [4];
  int hs_low = 0;
  int p;

  logic [0:15] l0_1 = 16'hA50F;
  logic [0:7]  l1_1 = 8'h81;
  logic [3:0]  l0_4 [8] = '{4'h3, 4'h3, 4'hC, 4'hC,
                            4'h1, 4'h1, 4'h2, 4'h2};
  logic [3:0]  l2_4 [4] = '{4'h5, 4'h5, 4'hA, 4'hA};

  always #5 clk = ~clk;

  vga_fb #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .BPP(1), .SCALE(1), .VMEM_BYTES(64)
  ) d1 (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .vmem_in_addr(addr), .vmem_in_data(data),
    .vmem_we(we1), .base_in(base_in), .base_we(base_we),
    .hsync(hs1), .vsync(vs1), .de(de1), .rgb(rgb1),
    .frame_irq(irq1)
  );

  vga_fb #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .BPP(4), .SCALE(2), .VMEM_BYTES(64)
  ) d4 (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .vmem_in_addr(addr), .vmem_in_data(data),
    .vmem_we(we4), .base_in(base_in), .base_we(base_we),
    .hsync(hs4), .vsync(vs4), .de(de4), .rgb(rgb4),
    .frame_irq(irq4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit to4, input int a, input int d);
    @(negedge clk);
    addr = AW'(a);
    data = 8'(d);
    if (to4) we4 = 1'b1;
    else     we1 = 1'b1;
    @(negedge clk);
    we1 = 1'b0;
    we4 = 1'b0;
  endtask

  task automatic wbase(input int b);
    @(negedge clk);
    base_in = AW'(b);
    base_we = 1'b1;
    @(negedge clk);
    base_we = 1'b0;
  endtask

  task automatic step(input int s);
    @(negedge clk);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    if (irq1) begin
      if (irq_n1 < 4) irq_at1[irq_n1] = s;
      irq_n1++;
    end
    if (irq4) irq_n4++;
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hs1"}, hs1, 1);
    chk({tag, "_vs1"}, vs1, 1);
    chk({tag, "_de1"}, de1, 0);
    chk({tag, "_rgb1"}, rgb1, 0);
    chk({tag, "_irq1"}, irq1, 0);
    chk({tag, "_hs4"}, hs4, 1);
    chk({tag, "_de4"}, de4, 0);
    chk({tag, "_rgb4"}, rgb4, 0);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("por");

    wr(0, 0, 'hA5);  wr(0, 1, 'h0F);  wr(0, 2, 'h81);
    wr(0, 4, 'hC0);  wr(0, 32, 'h80); wr(0, 62, 'hFF);
    wr(0, 63, 'h00);
    wr(1, 0, 'h3C);  wr(1, 1, 'h12);  wr(1, 4, 'h5A);
    wr(1, 32, 'hF0); wr(1, 62, 'h77); wr(1, 63, 'h00);
    chk_reset("idle");

    for (int s = 0; s < 520; s++) begin
      if (s == 30)  wbase(32);
      if (s == 300) wbase(62);
      step(s);
      p = s - 1;
      if (p >= 0 && p < 16) begin
        chk($sformatf("d1_l0_p%0d", p), rgb1, l0_1[p]);
        chk($sformatf("de1_p%0d", p), de1, 1);
      end
      if (p == 16) chk("de1_off", de1, 0);
      if (p >= 24 && p < 32)
        chk($sformatf("d1_l1_p%0d", p), rgb1, l1_1[p-24]);
      if (p == 48 || p == 49)
        chk($sformatf("d1_l2_p%0d", p), rgb1, 1);
      if (p >= 0 && p < 8)
        chk($sformatf("d4_l0_p%0d", p), rgb4, l0_4[p]);
      if (p >= 24 && p < 28)
        chk($sformatf("d4_l1_p%0d", p), rgb4, l0_4[p-24]);
      if (p >= 48 && p < 52)
        chk($sformatf("d4_l2_p%0d", p), rgb4, l2_4[p-48]);
      if (p >= 0 && p < 24 && hs1 == 1'b0) hs_low++;
      if (p == 17) chk("hs_p17", hs1, 1);
      if (p == 18) chk("hs_p18", hs1, 0);
      if (p == 20) chk("hs_p20", hs1, 0);
      if (p == 21) chk("hs_p21", hs1, 1);
      if (p == 167) chk("vs_p167", vs1, 1);
      if (p == 168) chk("vs_p168", vs1, 0);
      if (p == 215) chk("vs_p215", vs4, 0);
      if (p == 216) chk("vs_p216", vs4, 1);
      if (p == 150) begin
        chk("blank_de1", de1, 0);
        chk("blank_rgb1", rgb1, 0);
        chk("blank_rgb4", rgb4, 0);
      end
      if (p == 240) chk("f2_d1_p0", rgb1, 1);
      if (p == 241) chk("f2_d1_p1", rgb1, 0);
      if (p == 240) chk("f2_d4_p0", rgb4, 'hF);
      if (p == 242) chk("f2_d4_p2", rgb4, 0);
      if (p == 480) chk("wr_d1_p0", rgb1, 1);
      if (p == 488) chk("wr_d1_p8", rgb1, 0);
      if (p == 504) chk("wr_d1_l1p0", rgb1, 1);
      if (p == 505) chk("wr_d1_l1p1", rgb1, 0);
      if (p == 480) chk("wr_d4_p0", rgb4, 7);
      if (p == 484) chk("wr_d4_p4", rgb4, 0);
      if (p == 488) chk("wr_d4_p8", rgb4, 3);
      if (p == 490) chk("wr_d4_p10", rgb4, 'hC);
    end

    chk("hs_low_cnt", hs_low, 3);
    chk("irq1_cnt", irq_n1, 2);
    chk("irq4_cnt", irq_n4, 2);
    chk("irq1_at0", irq_at1[0], 144);
    chk("irq1_at1", irq_at1[1], 384);

    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("midrst");
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rel");

    for (int s = 0; s < 24; s++) begin
      step(1000 + s);
      p = s - 1;
      if (p == -1) begin
        chk("rs_de1_pre", de1, 0);
        chk("rs_hs1_pre", hs1, 1);
      end
      if (p == 0) begin
        chk("rs_d1_p0", rgb1, 1);
        chk("rs_de1_p0", de1, 1);
        chk("rs_d4_p0", rgb4, 3);
      end
      if (p == 1) chk("rs_d1_p1", rgb1, 0);
      if (p == 17) chk("rs_hs_p17", hs1, 1);
      if (p == 18) chk("rs_hs_p18", hs1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
